// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: byte/frame types, FSM encoding and
// the frame builder. Optional macro UART_TX_ARB_PARITY_EN selects even parity;
// without it the parity slot carries a constant mark (1).
package uart_tx_arbiter_pkg;

  typedef logic [7:0] BYTE;

  // Frame as shifted LSB first: bit 0 start, bits 8:1 data, bit 9 parity, bit 10 stop.
  typedef struct packed {
    logic stop;
    logic parity;
    BYTE  tx_byte;
    logic start;
  } tx_byte_stop;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_LAUNCH,
    ARB_WAIT,
    ARB_GAP
  } UART_ARB_FSM;

  localparam int UART_ARB_GAP_DEFAULT = 2;

  function automatic tx_byte_stop build_frame(input BYTE data);
    tx_byte_stop f;
    f.start   = 1'b0;
    f.tx_byte = data;
    f.stop    = 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
    f.parity  = ^data;
`else
    f.parity  = 1'b1;
`endif
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first asserted request at or after the pointer,
// wrapping around. Purely combinational.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic [GID_W-1:0]   winner,
  output logic               any_valid
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    logic [GID_W-1:0] cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART frame serializer among NUM_REQ byte
// producers. Builds the 11-bit frame, launches it with a one-cycle tx_start,
// waits for tx_done and then an inter-frame gap before arbitrating again.
// Optional macro UART_TX_ARB_PARITY_EN: even parity in the frame (else mark).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int GAP_CYCLES = UART_ARB_GAP_DEFAULT,
  localparam int GID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  BYTE  [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output tx_byte_stop              tx_frame,
  output logic                     tx_start,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [GID_W-1:0]         grant_id,
  output logic                     arb_busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  UART_ARB_FSM      state;
  logic [GID_W-1:0] ptr;
  logic [GID_W-1:0] next_ptr;
  logic [GID_W-1:0] winner;
  logic             any_valid;
  logic [GAP_W-1:0] gap_cnt;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + GID_W'(1);

  // Sequencer: arbitration, byte capture, launch, completion wait and gap count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      tx_frame <= '1;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A requester that withdrew its byte forfeits the grant; the
          // pointer is left alone so it is first in line again.
          if (req_valid[grant_id]) begin
            tx_frame <= build_frame(req_data[grant_id]);
            state    <= ARB_LAUNCH;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_LAUNCH: begin
          if (!tx_busy) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (tx_done) begin
            ptr     <= next_ptr;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
          end
        end
        ARB_GAP: begin
          if (int'(gap_cnt) >= GAP_CYCLES - 1) state <= ARB_IDLE;
          else                                 gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Accept pulse goes only to the granted requester, only while in GRANT.
  always_comb begin
    req_ready = '0;
    if (state == ARB_GRANT) req_ready[grant_id] = 1'b1;
  end

  assign tx_start = (state == ARB_LAUNCH) && !tx_busy;
  assign arb_busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized phase.
// Producers and a serializer are modelled on the driver side; a separate
// monitor predicts grants/timing from the round-robin and gap rules and
// pops expected frames from per-requester scoreboards on each tx_start.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 2;
  localparam int GID_W      = 2;
  localparam int BIG        = 1 << 30;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  BYTE  [NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]   req_ready;
  tx_byte_stop          tx_frame;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;
  logic [GID_W-1:0]     grant_id;
  logic                 arb_busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_frame  (tx_frame),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  BYTE         src_q [NUM_REQ][$];
  logic [10:0] exp_q [NUM_REQ][$];
  logic [12:0] start_log [$];

  int   ser_cnt    = 0;
  bit   done_pulse = 0;
  int   busy_force = 0;
  int   drop_cnt   = 0;
  logic [NUM_REQ-1:0] drop_mask = '0;
  bit   gen_en     = 0;
  bit   noise_en   = 0;
  bit   st_seen    = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input BYTE b);
    logic par;
`ifdef UART_TX_ARB_PARITY_EN
    par = ^b;
`else
    par = 1'b1;
`endif
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int p);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (v[idx[GID_W-1:0]]) return idx;
    end
    return 0;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_byte(input int i, input BYTE b);
    src_q[i].push_back(b);
    exp_q[i].push_back(exp_frame(b));
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src_q[i].size() > 0) && !(drop_cnt > 0 && drop_mask[i]);
      req_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    if (drop_cnt > 0) drop_cnt--;
  endtask

  // Sample the current cycle at negedge, then drive the next cycle after posedge.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    BYTE junk;
    int  r;
    @(negedge clk);
    hs      = req_ready & req_valid;
    st_seen = tx_start;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i] && src_q[i].size() > 0) junk = src_q[i].pop_front();
    tx_done    = done_pulse;
    done_pulse = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) tx_done = 1'b1;
    end
    if (st_seen && rst_n) ser_cnt = $urandom_range(2, 6);
    if (gen_en && $urandom_range(0, 2) == 0) begin
      r = $urandom_range(0, NUM_REQ - 1);
      if (src_q[r].size() < 3) push_byte(r, 8'($urandom));
    end
    tx_busy = (ser_cnt > 0) || (busy_force > 0) || (noise_en && $urandom_range(0, 3) == 0);
    if (busy_force > 0) busy_force--;
    drive();
  endtask

  task automatic wait_start(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!st_seen && n < 60);
    check_eq({name, "_start_seen"}, 32'(st_seen), 32'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((any_pending() || ser_cnt > 0 || arb_busy) && n < 600) begin
      step();
      n++;
    end
    check_eq("drain_in_time", 32'(n < 600), 32'(1));
    repeat (GAP_CYCLES + 3) step();
  endtask

  task automatic apply_reset(input int n);
    rst_n      = 1'b0;
    ser_cnt    = 0;
    tx_done    = 1'b0;
    tx_busy    = 1'b0;
    busy_force = 0;
    done_pulse = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard: predicts handshake and launch timing from the rules.
  initial begin : monitor
    int c, idle_from, pending_from, start_c, ptr, gid, w;
    bit pending, active, exp_rdy, exp_start;
    logic [NUM_REQ-1:0] prev_valid;
    logic [10:0] fr, cur, junk;
    c = 0; idle_from = 0; pending_from = 0; start_c = 0; ptr = 0; gid = 0; w = 0;
    pending = 0; active = 0; prev_valid = '0; cur = '1;
    forever begin
      @(negedge clk);
      fr = tx_frame;
      if (!rst_n) begin
        check_eq("rst_req_ready", 32'(req_ready), 32'(0));
        check_eq("rst_tx_start", 32'(tx_start), 32'(0));
        check_eq("rst_tx_frame", 32'(fr), 32'(11'h7FF));
        check_eq("rst_grant_id", 32'(grant_id), 32'(0));
        check_eq("rst_arb_busy", 32'(arb_busy), 32'(0));
        if (pending && exp_q[gid].size() > 0) junk = exp_q[gid].pop_front();
        pending = 0; active = 0; ptr = 0; idle_from = c + 1;
      end else begin
        exp_rdy = (c - 1 >= idle_from) && (prev_valid != '0);
        if (exp_rdy) idle_from = BIG;
        check_eq("ready_any", 32'(|req_ready), 32'(exp_rdy));
        check_eq("ready_at_most_one", 32'($countones(req_ready) <= 1), 32'(1));
        check_eq("arb_busy", 32'(arb_busy), 32'(c < idle_from));
        if (exp_rdy) begin
          w = model_pick(prev_valid, ptr);
          check_eq("grant_ready_bit", 32'(req_ready), 32'(1) << w);
          check_eq("grant_id", 32'(grant_id), 32'(w));
          gid = w;
          if (req_valid[w[GID_W-1:0]]) begin
            pending = 1; pending_from = c + 1;
          end else begin
            idle_from = c + 1;
          end
        end
        exp_start = pending && (c >= pending_from) && !tx_busy;
        check_eq("tx_start", 32'(tx_start), 32'(exp_start));
        if (pending && c >= pending_from) begin
          check_eq("frame_expected_avail", 32'(exp_q[gid].size() > 0), 32'(1));
          if (exp_q[gid].size() > 0) check_eq("frame_launch", 32'(fr), 32'(exp_q[gid][0]));
          check_eq("grant_id_hold", 32'(grant_id), 32'(gid));
          if (exp_start) begin
            if (exp_q[gid].size() > 0) cur = exp_q[gid].pop_front();
            start_log.push_back({GID_W'(gid), fr});
            pending = 0; active = 1; start_c = c;
          end
        end else if (active) begin
          check_eq("frame_stable", 32'(fr), 32'(cur));
          check_eq("grant_id_stable", 32'(grant_id), 32'(gid));
        end
        if (active && tx_done && c > start_c) begin
          active = 0;
          ptr = (gid + 1) % NUM_REQ;
          idle_from = c + 1 + GAP_CYCLES;
        end
      end
      prev_valid = req_valid;
      c++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int n, base;
    logic [12:0] e;
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single requester 2 with 0xA5: two-cycle launch latency, spec frame.
    push_byte(2, 8'hA5);
    wait_start("t1", n);
    check_eq("t1_latency", 32'(n), 32'(4));
    e = start_log[start_log.size() - 1];
    check_eq("t1_grant", 32'(e[12:11]), 32'(2));
`ifdef UART_TX_ARB_PARITY_EN
    check_eq("t1_frame", 32'(e[10:0]), 32'(11'h54A));
`else
    check_eq("t1_frame", 32'(e[10:0]), 32'(11'h74A));
`endif
    drain();

    // Requester 1 withdraws valid in GRANT, then re-asserts.
    base = start_log.size();
    push_byte(1, 8'h3C);
    step();
    drop_mask = 4'b0010;
    drop_cnt  = 2;
    wait_start("t4", n);
    e = start_log[start_log.size() - 1];
    check_eq("t4_regrant", 32'(e[12:11]), 32'(1));
    drain();
    check_eq("t4_single_start", 32'(start_log.size() - base), 32'(1));

    // Serializer busy for 5 cycles while in LAUNCH.
    push_byte(0, 8'h5A);
    step();
    step();
    busy_force = 5;
    wait_start("t3", n);
    check_eq("t3_start_delay", 32'(n), 32'(7));
    drain();

    // tx_done in IDLE, then coincident with tx_start: both ignored.
    base = start_log.size();
    done_pulse = 1'b1;
    repeat (4) step();
    check_eq("t6_idle_after_done", 32'(arb_busy), 32'(0));
    push_byte(2, 8'hC3);
    step();
    step();
    done_pulse = 1'b1;
    step();
    step();
    check_eq("t6_still_waiting", 32'(arb_busy), 32'(1));
    drain();
    check_eq("t6_single_start", 32'(start_log.size() - base), 32'(1));

    // Reset while waiting for tx_done; afterwards requester 3 at normal latency.
    push_byte(0, 8'h81);
    wait_start("t5a", n);
    apply_reset(2);
    repeat (3) step();
    check_eq("t5_idle_after_release", 32'(arb_busy), 32'(0));
    push_byte(3, 8'h7E);
    wait_start("t5b", n);
    check_eq("t5_latency", 32'(n), 32'(4));
    e = start_log[start_log.size() - 1];
    check_eq("t5_grant", 32'(e[12:11]), 32'(3));
    drain();

    // All four requesters loaded: strict rotation from pointer 0.
    base = start_log.size();
    for (int r = 0; r < NUM_REQ; r++) begin
      push_byte(r, 8'(8'h10 + r));
      push_byte(r, 8'(8'h20 + r));
    end
    drain();
    check_eq("t2_start_count", 32'(start_log.size() - base), 32'(2 * NUM_REQ));
    for (int k = 0; k < 2 * NUM_REQ; k++) begin
      if (base + k < start_log.size()) begin
        e = start_log[base + k];
        check_eq("t2_rotation", 32'(e[12:11]), 32'(k % NUM_REQ));
      end
    end

    // Randomized traffic with random serializer stalls.
    gen_en   = 1'b1;
    noise_en = 1'b1;
    repeat (2500) step();
    gen_en = 1'b0;
    drain();
    noise_en = 1'b0;
    for (int r = 0; r < NUM_REQ; r++)
      check_eq("scoreboard_empty", 32'(exp_q[r].size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
